// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for a 5-stage pipeline: EX operand mux selects,
// load-use / branch / multi-cycle stall and flush strobes, and a private copy of
// the EX/MEM/WB destination tags.
module hazard_fwd_ctrl #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned MDU_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mdu,
  input  logic                ex_branch_taken,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                mdu_busy
);

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic                mdu;
  } tag_t;

  tag_t             id_tag;
  tag_t             ex_q;
  tag_t             mem_q;
  tag_t             wb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic busy;
  logic branch;
  logic load_use;
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // Not every tag field feeds a decision in every stage; keep them for visibility.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{ex_q, mem_q, wb_q};

  // Capture the ID-stage instruction as a tag; invalid slots are fully cleared.
  always_comb begin
    id_tag = '0;
    if (id_valid) begin
      id_tag.valid     = 1'b1;
      id_tag.rs1       = id_rs1;
      id_tag.rs2       = id_rs2;
      id_tag.rd        = id_rd;
      id_tag.reg_write = id_reg_write;
      id_tag.mem_read  = id_mem_read;
      id_tag.mdu       = id_mdu;
    end
  end

  // Hazard detection; run_q keeps every strobe quiet in the first cycle out of reset.
  always_comb begin
    busy     = (cnt_q != '0);
    branch   = run_q & ex_branch_taken & ~busy;
    load_use = run_q & ~busy & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
               id_valid & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  end

  // Operand forwarding from the registered MEM/WB tags; MEM is newer so it wins.
  always_comb begin
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    mem_fwd_ok = run_q & mem_q.valid & mem_q.reg_write & (mem_q.rd != '0) & ~mem_q.mem_read;
    wb_fwd_ok  = run_q & wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);
    if (mem_fwd_ok && (mem_q.rd == ex_q.rs1)) begin
      fwd_a_sel = 2'b10;
    end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs1)) begin
      fwd_a_sel = 2'b01;
    end
    if (mem_fwd_ok && (mem_q.rd == ex_q.rs2)) begin
      fwd_b_sel = 2'b10;
    end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs2)) begin
      fwd_b_sel = 2'b01;
    end
  end

  // Stall/flush strobes; a taken branch overrides a load-use stall.
  always_comb begin
    mdu_busy = busy;
    stall_f  = busy | (load_use & ~branch);
    stall_d  = busy | (load_use & ~branch);
    flush_d  = branch;
    flush_e  = branch | load_use;
  end

  // Tag pipeline and multi-cycle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      wb_q  <= mem_q;
      if (busy) begin
        mem_q <= '0;
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        mem_q <= ex_q;
        if (branch || load_use) begin
          ex_q  <= '0;
          cnt_q <= '0;
        end else begin
          ex_q  <= id_tag;
          cnt_q <= id_tag.mdu ? CNT_W'(MDU_LAT - 1) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench for hazard_fwd_ctrl: the driver queues the expected
// output vector for each cycle, a monitor pops and compares at the falling edge.
module tb_hazard_fwd_ctrl;

  localparam int unsigned REG_BITS = 5;
  localparam int unsigned MDU_LAT  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs1, id_rs2, id_rd;
  logic                id_reg_write, id_mem_read, id_mdu, ex_branch_taken;
  logic [1:0]          fwd_a_sel, fwd_b_sel;
  logic                stall_f, stall_d, flush_d, flush_e, mdu_busy;

  typedef struct {
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [8:0] Z = 9'b0;

  hazard_fwd_ctrl #(.REG_BITS(REG_BITS), .MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mdu(id_mdu), .ex_branch_taken(ex_branch_taken), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e, mdu_busy}
  function automatic logic [8:0] e(input logic [1:0] a, input logic [1:0] b, input logic sf,
                                   input logic sd, input logic fd, input logic fe,
                                   input logic mb);
    return {a, b, sf, sd, fd, fe, mb};
  endfunction

  // Drive one ID-stage slot just after the rising edge and queue what this cycle must show.
  task automatic cyc(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic rw, input logic mr, input logic md,
                     input logic br, input logic [8:0] ev, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_reg_write = rw; id_mem_read = mr; id_mdu = md; ex_branch_taken = br;
    x.v = ev; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic nop(input logic [8:0] ev, input string nm);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev, nm);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t       x;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x   = q.pop_front();
        act = {fwd_a_sel, fwd_b_sel, stall_f, stall_d, flush_d, flush_e, mdu_busy};
        n_checks++;
        if (act === x.v) n_pass++;
        else $display("FAIL %s: got %b want %b (a,b,sf,sd,fd,fe,mb)", x.nm, act, x.v);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mdu = 1'b0; ex_branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // Reset and first cycle after release stay silent even with a branch strobe.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, Z, "rst_hold_br");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, Z, "rst_first_br");
    rst_n = 1'b1;

    // MEM forwarding, WB forwarding, MEM-over-WB priority.
    cyc(1, 1, 2, 5, 1, 0, 0, 0, Z, "add_x5_id");
    cyc(1, 5, 5, 6, 1, 0, 0, 0, Z, "consumer_id");
    nop(e(2'b10, 2'b10, 0, 0, 0, 0, 0), "fwd_mem");
    nop(Z, "drain1");
    cyc(1, 1, 2, 5, 1, 0, 0, 0, Z, "add_x5_id2");
    nop(Z, "gap");
    cyc(1, 5, 5, 6, 1, 0, 0, 0, Z, "consumer_id2");
    nop(e(2'b01, 2'b01, 0, 0, 0, 0, 0), "fwd_wb");
    cyc(1, 1, 2, 5, 1, 0, 0, 0, Z, "add_x5_a");
    cyc(1, 1, 2, 5, 1, 0, 0, 0, Z, "add_x5_b");
    cyc(1, 5, 5, 6, 1, 0, 0, 0, Z, "consumer_id3");
    nop(e(2'b10, 2'b10, 0, 0, 0, 0, 0), "fwd_mem_over_wb");
    nop(Z, "drain2");

    // Load-use: one stall cycle, then WB forwarding to the consumer.
    cyc(1, 1, 0, 7, 1, 1, 0, 0, Z, "lw_x7_id");
    cyc(1, 2, 7, 8, 1, 0, 0, 0, e(2'b00, 2'b00, 1, 1, 0, 1, 0), "load_use");
    cyc(1, 2, 7, 8, 1, 0, 0, 0, Z, "load_use_once");
    nop(e(2'b00, 2'b01, 0, 0, 0, 0, 0), "lw_fwd_wb");

    // x0 never stalls and never forwards.
    cyc(1, 1, 0, 0, 1, 1, 0, 0, Z, "lw_x0_id");
    cyc(1, 0, 0, 0, 1, 0, 0, 0, Z, "x0_no_stall");
    cyc(1, 0, 0, 9, 1, 0, 0, 0, Z, "x0_reader_id");
    nop(Z, "x0_no_fwd");

    // Multi-cycle op: 3 busy cycles, MEM bubbles while WB keeps draining.
    cyc(1, 1, 2, 10, 1, 0, 0, 0, Z, "add_x10_id");
    cyc(1, 10, 2, 11, 1, 0, 1, 0, Z, "mul_id");
    cyc(1, 10, 11, 12, 1, 0, 0, 0, e(2'b10, 2'b00, 1, 1, 0, 0, 1), "mdu_busy1");
    cyc(1, 10, 11, 12, 1, 0, 0, 0, e(2'b01, 2'b00, 1, 1, 0, 0, 1), "mdu_busy2");
    cyc(1, 10, 11, 12, 1, 0, 0, 0, e(2'b00, 2'b00, 1, 1, 0, 0, 1), "mdu_busy3");
    cyc(1, 10, 11, 12, 1, 0, 0, 0, Z, "mdu_done");
    nop(e(2'b00, 2'b10, 0, 0, 0, 0, 0), "fwd_after_mdu");

    // Branch together with a load-use hazard: flush wins, no stall.
    cyc(1, 1, 0, 3, 1, 1, 0, 0, Z, "lw_x3_id");
    cyc(1, 3, 4, 13, 1, 0, 0, 1, e(2'b00, 2'b00, 0, 0, 1, 1, 0), "flush_over_lu");
    nop(Z, "after_flush");

    // Branch ignored while busy, then asynchronous reset mid-countdown.
    cyc(1, 0, 0, 14, 1, 0, 1, 0, Z, "mul2_id");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, e(2'b00, 2'b00, 1, 1, 0, 0, 1), "br_ignored_busy");
    nop(e(2'b00, 2'b00, 1, 1, 0, 0, 1), "mdu2_busy");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, Z, "async_rst");
    rst_n = 1'b0;
    nop(Z, "rst_held");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, Z, "rel_first_br");
    rst_n = 1'b1;
    cyc(0, 5, 5, 5, 1, 0, 0, 0, Z, "idle1");
    cyc(0, 5, 5, 5, 1, 1, 1, 0, Z, "idle2");
    nop(Z, "idle3");
    cyc(1, 1, 1, 1, 1, 0, 0, 1, e(2'b00, 2'b00, 0, 0, 1, 1, 0), "branch");
    nop(Z, "after_branch");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
